instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Multi-cycle instruction fetch sequencer that sources the 32-bit instruction word, and therefore the opcode, consumed by the main control decoder. It also consumes that decoder's Branch and Jump outputs to select the next program counter. It owns the PC, runs a request/ready handshake with instruction memory, and holds each fetched instruction stable until the datapath signals completion.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_ready  input  1  memory response strobe; imem_rdata valid in the same cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  held instruction; instr[31:26] drives the decoder opcode.
- instr_valid  output  1  instr holds a fetched, not-yet-retired instruction.
- pc_plus4  output  32  pc + 4 of the held instruction.
- advance  input  1  datapath has finished the held instruction; redirect inputs are valid this cycle.
- branch  input  1  Branch from main control.
- zero  input  1  ALU zero flag.
- jump  input  2  Jump from main control: 00 sequential, 01 J-format, 10 register (jr), 11 reserved.
- jr_addr  input  32  register jump target.
- fetch_count  output  32  number of instructions retired since reset.

## Operation
- FSM states: IDLE, FETCH, HOLD.
- IDLE is entered on reset. It lasts exactly one cycle after reset deasserts, then goes to FETCH.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both stable until imem_ready.
  - On imem_ready: latch imem_rdata into instr, set instr_valid, go to HOLD.
- HOLD:
  - instr and instr_valid are held. imem_req = 0.
  - On advance: clear instr_valid, load pc with next_pc, increment fetch_count, go to FETCH.
- next_pc priority:
  - jump = 01 gives {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Otherwise jump = 10 gives {jr_addr[31:2], 2'b00}, with low bits forced to zero.
  - Otherwise branch & zero gives pc_plus4 + {sext(instr[15:0]), 2'b00}, using 32-bit modulo arithmetic.
  - Otherwise, including jump = 11, next_pc is pc_plus4.
- Wrap-around: pc_plus4 and branch targets wrap modulo 2^32. fetch_count wraps 0xFFFF_FFFF to 0.
- Ignored inputs:
  - advance outside HOLD is ignored and has no counter effect.
  - imem_ready outside FETCH is ignored.
- Reset mid-fetch: the outstanding request is abandoned. pc = RESET_PC. A late imem_ready in IDLE is ignored.

## Timing
- Values while reset is high (and the cycle after):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - imem_req = 0, instr = 0, instr_valid = 0, fetch_count = 0.
  - pc_plus4 = RESET_PC + 4.
- First imem_req is asserted two cycles after the cycle in which reset is last sampled high.
- imem_ready sampled high in cycle N gives instr and instr_valid = 1 in cycle N+1.
- Zero-wait memory (imem_ready high in the first FETCH cycle) costs one cycle per fetch.
- advance sampled in cycle M gives:
  - instr_valid = 0, new imem_addr and imem_req = 1, all in cycle M+1.
  - fetch_count incremented in M+1.
- Minimum throughput: one instruction per 2 cycles, i.e. FETCH with immediate ready, then HOLD with immediate advance.
- All outputs are registered except imem_addr (a wire from pc) and pc_plus4 (combinational from pc).

## Structure
- Shared package mips_pkg holds:
  - jump encodings JUMP_SEQ, JUMP_J, JUMP_JR, JUMP_RSVD.
  - FSM state constants.
  - RESET_PC default.
  - The main control decoder uses the same jump encodings.
- One combinational sub-module, next_pc_calc. Inputs: pc_plus4, instr, branch, zero, jump, jr_addr. Output: next_pc. It is unit-tested standalone.

## Test plan
- Reset, then instant-ready memory returning 0x8C010004 (lw) at 0x0 → imem_req first high 2 cycles after reset release; instr = 0x8C010004 one cycle after ready; advance → imem_addr = 0x4.
- HOLD at pc = 0x100 with instr = 0x1000FFFF (beq, imm -1), branch = 1, zero = 1, advance → imem_addr = 0x100 (0x104 − 4). Same with zero = 0 → imem_addr = 0x104.
- jump = 01, instr = 0x08000040, pc = 0x40000000 → 0x40000100. jump = 10 with jr_addr = 0x123 → 0x120. jump = 01 and branch = zero = 1 together → J target wins.
- Memory with 3-cycle ready latency → imem_req and imem_addr stable for all 3 cycles. advance pulsed during FETCH → ignored, fetch_count unchanged.
- Reset asserted mid-FETCH, then imem_ready pulsed during IDLE → instr_valid stays 0, pc = RESET_PC, the next fetch goes to RESET_PC.
- pc = 0xFFFFFFFC sequential advance → imem_addr = 0x0. fetch_count preloaded via 2^32 − 1 advances (or forced) wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch sequencer and the main control decoder:
// jump encodings, fetch FSM states and the reset PC.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] JUMP_SEQ  = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;
    localparam logic [1:0] JUMP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Word offset of a branch immediate, sign-extended to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter selection: J-format, register jump, taken branch, sequential.
// Purely combinational; jump has priority over branch.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc
);

    logic unused_bits;
    assign unused_bits = ^{instr[31:26], jr_addr[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        case (jump)
            JUMP_J:  next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            JUMP_JR: next_pc = {jr_addr[31:2], 2'b00};
            JUMP_SEQ, JUMP_RSVD: begin
                if (branch && zero) begin
                    next_pc = pc_plus4 + branch_offset(instr[15:0]);
                end
            end
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch sequencer: owns the PC, handshakes with
// instruction memory and holds each instruction until the datapath retires it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | one-cycle pause after reset, no request outstanding
//   ST_FETCH | imem_req high at pc, waiting for imem_ready
//   ST_HOLD  | instr valid and held, waiting for advance
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        branch,
    input  logic        zero,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_addr,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .jr_addr  (jr_addr),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Request is registered, so it follows the state being entered.
        imem_req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
